// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer: the word type, reset/step defaults
// and the sequencer state encoding.
package pc_seq_pkg;

  typedef logic [31:0] word_t;

  localparam word_t ResetPcDefault = 32'h0000_0000;
  localparam word_t PcStepDefault  = 32'd4;

  typedef enum logic [1:0] {
    StIdle,
    StInc,
    StBr,
    StCommit
  } state_e;

endpackage

// File: rtl/pc_sequencer_adder.sv
// 32-bit modulo adder shared by the sequencer for both the PC increment and the branch target.
module BEQAdder
  import pc_seq_pkg::*;
(
  input  word_t ValueIn1,
  input  word_t ValueIn2,
  output word_t ValueOut
);

  // Carry out is discarded: all PC arithmetic wraps modulo 2^32.
  assign ValueOut = ValueIn1 + ValueIn2;

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle next-PC sequencer for BEQ: increments the PC, optionally adds the branch
// offset, then commits. One shared adder serves both steps.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter word_t RESET_PC = ResetPcDefault,
  parameter word_t PC_STEP  = PcStepDefault
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        StartValid,
  output logic        StartReady,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] ImmExt,
  output logic [31:0] Pc,
  output logic        PcValid,
  output logic        Taken
);

  state_e state_q, state_d;
  word_t  pc_q, pc_d;
  word_t  pc_plus4_q, pc_plus4_d;
  word_t  target_q, target_d;
  word_t  imm_q, imm_d;
  logic   branch_q, branch_d;
  logic   zero_q, zero_d;

  word_t  add_a, add_b, add_sum;
  logic   taken;

  assign taken = branch_q & zero_q;

  // Operand mux: BR adds the scaled offset to PcPlus4, every other state steps the PC.
  always_comb begin
    add_a = pc_q;
    add_b = PC_STEP;
    if (state_q == StBr) begin
      add_a = pc_plus4_q;
      add_b = {imm_q[29:0], 2'b00};
    end
  end

  BEQAdder u_adder (
    .ValueIn1 (add_a),
    .ValueIn2 (add_b),
    .ValueOut (add_sum)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    target_d   = target_q;
    imm_d      = imm_q;
    branch_d   = branch_q;
    zero_d     = zero_q;
    unique case (state_q)
      StIdle: begin
        if (StartValid) begin
          branch_d = Branch;
          zero_d   = Zero;
          imm_d    = ImmExt;
          state_d  = StInc;
        end
      end
      StInc: begin
        pc_plus4_d = add_sum;
        state_d    = taken ? StBr : StCommit;
      end
      StBr: begin
        target_d = add_sum;
        state_d  = StCommit;
      end
      StCommit: begin
        pc_d    = taken ? target_q : pc_plus4_q;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      pc_plus4_q <= '0;
      target_q   <= '0;
      imm_q      <= '0;
      branch_q   <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      target_q   <= target_d;
      imm_q      <= imm_d;
      branch_q   <= branch_d;
      zero_q     <= zero_d;
    end
  end

  // PcValid/Taken decode from state; the new Pc value is visible from the cycle after the pulse.
  assign StartReady = (state_q == StIdle) & ResetN;
  assign PcValid    = (state_q == StCommit);
  assign Taken      = PcValid & taken;
  assign Pc         = pc_q;

endmodule
